// File: rtl/ifu_fetch_axi_ctrl_if.sv
// AXI4 read-side bus (AR + R channels) between the IFU fetch controller and the interconnect.
// The controller side uses the master modport; the interconnect or a bench uses slave.
interface ifu_fetch_axi_ctrl_if #(
    parameter int AxiIdW = 4,
    parameter int DataW  = 64
);
    logic [AxiIdW-1:0] axi_arid_f;
    logic [31:0]       axi_araddr_f;
    logic [7:0]        axi_arlen_f;
    logic [2:0]        axi_arsize_f;
    logic [1:0]        axi_arburst_f;
    logic              axi_arlock_f;
    logic [3:0]        axi_arcache_f;
    logic [2:0]        axi_arprot_f;
    logic              axi_arvalid_f;
    logic [3:0]        axi_arqos_f;
    logic [3:0]        axi_arregion_f;
    logic              axi_arready_f;

    logic [AxiIdW-1:0] axi_rid_f;
    logic [DataW-1:0]  axi_rdata_f;
    logic [1:0]        axi_rresp_f;
    logic              axi_rlast_f;
    logic              axi_rvalid_f;
    logic              axi_rready_f;

    modport master (
        output axi_arid_f, axi_araddr_f, axi_arlen_f, axi_arsize_f, axi_arburst_f,
               axi_arlock_f, axi_arcache_f, axi_arprot_f, axi_arvalid_f,
               axi_arqos_f, axi_arregion_f,
        input  axi_arready_f,
        input  axi_rid_f, axi_rdata_f, axi_rresp_f, axi_rlast_f, axi_rvalid_f,
        output axi_rready_f
    );

    modport slave (
        input  axi_arid_f, axi_araddr_f, axi_arlen_f, axi_arsize_f, axi_arburst_f,
               axi_arlock_f, axi_arcache_f, axi_arprot_f, axi_arvalid_f,
               axi_arqos_f, axi_arregion_f,
        output axi_arready_f,
        output axi_rid_f, axi_rdata_f, axi_rresp_f, axi_rlast_f, axi_rvalid_f,
        input  axi_rready_f
    );
endinterface

// File: rtl/ifu_fetch_axi_ctrl.sv
// IFU instruction-line refill controller: issues critical-beat-first WRAP bursts on AR,
// tracks up to NumOut bursts in flight, forwards R beats and drops beats of flushed bursts.
module ifu_fetch_axi_ctrl #(
    parameter int AxiIdW    = 4,
    parameter int DataW     = 64,
    parameter int LineBytes = 32,
    parameter int NumOut    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:1]      req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DataW-1:0] rsp_data,
    output logic             rsp_err,
    output logic             rsp_last,
    output logic             protocol_err,
    ifu_fetch_axi_ctrl_if.master axi
);

    localparam int ByteW = DataW / 8;
    localparam int SizeL = $clog2(ByteW);
    localparam int Beats = LineBytes / ByteW;
    localparam int CntW  = $clog2(NumOut + 1);
    localparam int PtrW  = (NumOut > 1) ? $clog2(NumOut) : 1;

    localparam logic [CntW-1:0] NumOutC  = CntW'(NumOut);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(NumOut - 1);
    localparam logic [3:0]      LastBeat = 4'(Beats - 1);
    localparam logic [31:0]     AddrMask = ~32'(ByteW - 1);

    if (!(DataW == 32 || DataW == 64 || DataW == 128)) begin : g_bad_dataw
        $error("DataW must be 32, 64 or 128");
    end
    if (LineBytes < ByteW || (LineBytes & (LineBytes - 1)) != 0 || Beats > 16) begin : g_bad_line
        $error("LineBytes must be a power of two, >= DataW/8, with at most 16 beats");
    end
    if (NumOut < 1) begin : g_bad_numout
        $error("NumOut must be at least 1");
    end

    typedef enum logic {
        AR_IDLE,
        AR_PEND
    } ar_state_e;

    ar_state_e         state_q, state_d;
    logic [31:0]       araddr_q;
    logic [NumOut-1:0] stale_q;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [3:0]        beat_q;
    logic              perr_q;

    logic push, pop, r_hs, empty, head_stale, last_ok;

    function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d           = state_q;
        req_ready         = 1'b0;
        axi.axi_arvalid_f = 1'b0;
        case (state_q)
            AR_IDLE: begin
                req_ready = rst_n && (count_q < NumOutC) && !clr;
                if (req_valid && req_ready) begin
                    state_d = AR_PEND;
                end
            end
            AR_PEND: begin
                axi.axi_arvalid_f = 1'b1;
                if (axi.axi_arready_f) begin
                    state_d = AR_IDLE;
                end
            end
        endcase
    end

    assign push = req_valid && req_ready;

    assign axi.axi_arid_f     = '0;
    assign axi.axi_araddr_f   = araddr_q;
    assign axi.axi_arlen_f    = 8'(Beats - 1);
    assign axi.axi_arsize_f   = 3'(SizeL);
    assign axi.axi_arburst_f  = 2'b10;
    assign axi.axi_arlock_f   = 1'b0;
    assign axi.axi_arcache_f  = 4'b0011;
    assign axi.axi_arprot_f   = 3'b100;
    assign axi.axi_arqos_f    = 4'd0;
    assign axi.axi_arregion_f = 4'd0;

    // Beats of flushed bursts are always accepted so the interconnect drains them.
    assign empty            = (count_q == '0);
    assign head_stale       = stale_q[rd_ptr_q];
    assign axi.axi_rready_f = empty || head_stale || rsp_ready;
    assign rsp_valid        = axi.axi_rvalid_f && !empty && !head_stale;
    assign rsp_data         = axi.axi_rdata_f;
    assign rsp_err          = axi.axi_rresp_f[1];
    assign rsp_last         = axi.axi_rlast_f;
    assign protocol_err     = perr_q;

    assign r_hs    = axi.axi_rvalid_f && axi.axi_rready_f;
    assign pop     = r_hs && axi.axi_rlast_f && !empty;
    assign last_ok = (axi.axi_rlast_f == (beat_q == LastBeat));

    logic unused_ok;
    assign unused_ok = axi.axi_rresp_f[0];

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= AR_IDLE;
            araddr_q <= '0;
            // NOTE: the stale bits are cleared too, so head_stale is never X when the FIFO is empty.
            stale_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (push) begin
                araddr_q <= {req_addr, 1'b0} & AddrMask;
                wr_ptr_q <= bump(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= bump(rd_ptr_q);
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            for (int i = 0; i < NumOut; i++) begin
                if (clr) begin
                    stale_q[i] <= 1'b1;
                end else if (push && wr_ptr_q == PtrW'(i)) begin
                    stale_q[i] <= 1'b0;
                end
            end

            if (r_hs) begin
                beat_q <= axi.axi_rlast_f ? 4'd0 : beat_q + 1'b1;
                if (empty || !last_ok || axi.axi_rid_f != '0) begin
                    perr_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch_axi_ctrl.sv
// Self-checking bench for ifu_fetch_axi_ctrl: directed vector table and corner sequences, then
// randomized traffic, all checked every cycle against a queue-based reference model.
module tb_ifu_fetch_axi_ctrl;

    localparam int AxiIdW    = 4;
    localparam int DataW     = 64;
    localparam int LineBytes = 32;
    localparam int NumOut    = 2;
    localparam int ByteW     = DataW / 8;
    localparam int Beats     = LineBytes / ByteW;

    logic        clk = 1'b0;
    logic        rst_n, clr, req_valid, req_ready;
    logic [31:1] req_addr;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err, rsp_last, protocol_err;

    always #5 clk = ~clk;

    ifu_fetch_axi_ctrl_if #(.AxiIdW(AxiIdW), .DataW(DataW)) axi_bus ();

    ifu_fetch_axi_ctrl #(
        .AxiIdW(AxiIdW), .DataW(DataW), .LineBytes(LineBytes), .NumOut(NumOut)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_last(rsp_last), .protocol_err(protocol_err),
        .axi(axi_bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    typedef struct {
        logic [31:0] byte_addr;
        logic [31:0] exp_araddr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: AR pending flag, in-flight bursts as a queue of stale flags.
    bit          m_ar_pend;
    logic [31:0] m_araddr;
    bit          sq[$];
    int          m_beat;
    bit          m_perr;
    bit          last_req_hs;

    bit e_req_ready, e_rready, s_arvalid, s_rready, s_rvalid;

    // Slave behaviour.
    beat_t       bq[$];
    beat_t       dq[$];
    int          ar_prob = 100, r_prob = 100, rsp_prob = 0, err_beat = -1;
    bit          short_burst = 0, bad_id = 0, rand_resp = 0;
    logic [31:0] seq = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic slave_drive();
        axi_bus.axi_arready_f = (int'($urandom_range(99)) < ar_prob);
        if (rst_n && bq.size() > 0 && int'($urandom_range(99)) < r_prob) begin
            axi_bus.axi_rvalid_f = 1'b1;
            axi_bus.axi_rdata_f  = bq[0].data;
            axi_bus.axi_rresp_f  = bq[0].resp;
            axi_bus.axi_rlast_f  = bq[0].last;
            axi_bus.axi_rid_f    = bq[0].id;
        end else begin
            axi_bus.axi_rvalid_f = 1'b0;
            axi_bus.axi_rdata_f  = {$urandom, $urandom};
            axi_bus.axi_rresp_f  = 2'b00;
            axi_bus.axi_rlast_f  = 1'b0;
            axi_bus.axi_rid_f    = '0;
        end
        rsp_ready = (int'($urandom_range(99)) < rsp_prob);
    endtask

    task automatic compare();
        bit m_empty, m_hstale, e_rsp_valid;
        beat_t d;
        s_arvalid = axi_bus.axi_arvalid_f;
        s_rready  = axi_bus.axi_rready_f;
        s_rvalid  = axi_bus.axi_rvalid_f;
        if (!rst_n) begin
            check("req_ready_in_reset", req_ready, 0);
            return;
        end
        m_empty     = (sq.size() == 0);
        m_hstale    = !m_empty && sq[0];
        e_req_ready = !m_ar_pend && sq.size() < NumOut && !clr;
        e_rready    = m_empty || m_hstale || rsp_ready;
        e_rsp_valid = axi_bus.axi_rvalid_f && !m_empty && !m_hstale;

        check("req_ready", req_ready, e_req_ready);
        check("arvalid", axi_bus.axi_arvalid_f, m_ar_pend);
        if (m_ar_pend) begin
            check("araddr", axi_bus.axi_araddr_f, m_araddr);
            check("arlen", axi_bus.axi_arlen_f, Beats - 1);
            check("arsize", axi_bus.axi_arsize_f, $clog2(ByteW));
            check("arburst", axi_bus.axi_arburst_f, 2'b10);
            check("arcache", axi_bus.axi_arcache_f, 4'b0011);
            check("arprot", axi_bus.axi_arprot_f, 3'b100);
            check("ar_zero_fields", {axi_bus.axi_arid_f, axi_bus.axi_arlock_f,
                                     axi_bus.axi_arqos_f, axi_bus.axi_arregion_f}, 0);
        end
        check("rready", axi_bus.axi_rready_f, e_rready);
        check("rsp_valid", rsp_valid, e_rsp_valid);
        if (e_rsp_valid) begin
            check("rsp_data", rsp_data, axi_bus.axi_rdata_f);
            check("rsp_err", rsp_err, axi_bus.axi_rresp_f[1]);
            check("rsp_last", rsp_last, axi_bus.axi_rlast_f);
        end
        check("protocol_err", protocol_err, m_perr);
        if (rsp_valid && rsp_ready) begin
            d.data = rsp_data;
            d.resp = {rsp_err, 1'b0};
            d.last = rsp_last;
            d.id   = '0;
            dq.push_back(d);
        end
    endtask

    task automatic model_update();
        bit m_empty, r_hs;
        logic [31:0] byte_addr;
        if (!rst_n) begin
            m_ar_pend = 0; m_araddr = '0; sq.delete(); m_beat = 0; m_perr = 0; last_req_hs = 0;
            return;
        end
        m_empty     = (sq.size() == 0);
        r_hs        = s_rvalid && e_rready;
        last_req_hs = req_valid && e_req_ready;
        if (r_hs) begin
            if (m_empty || axi_bus.axi_rid_f != 0 ||
                (axi_bus.axi_rlast_f != (m_beat == Beats - 1)))
                m_perr = 1;
            m_beat = axi_bus.axi_rlast_f ? 0 : (m_beat + 1) % 16;
            if (axi_bus.axi_rlast_f && !m_empty) void'(sq.pop_front());
        end
        if (clr) foreach (sq[i]) sq[i] = 1'b1;
        if (last_req_hs) sq.push_back(clr);
        if (m_ar_pend && axi_bus.axi_arready_f) m_ar_pend = 0;
        if (last_req_hs) begin
            byte_addr = {req_addr, 1'b0};
            m_ar_pend = 1;
            m_araddr  = (byte_addr / ByteW) * ByteW;
        end
    endtask

    task automatic slave_update();
        beat_t b;
        int n;
        if (s_rvalid && s_rready && bq.size() > 0) void'(bq.pop_front());
        if (rst_n && s_arvalid && axi_bus.axi_arready_f) begin
            n = short_burst ? 2 : Beats;
            for (int i = 0; i < n; i++) begin
                b.data = {$urandom, seq};
                seq++;
                b.resp = rand_resp ? 2'($urandom) : ((i == err_beat) ? 2'b10 : 2'b00);
                b.last = (i == n - 1);
                b.id   = (bad_id && i == 0) ? 4'h5 : 4'h0;
                bq.push_back(b);
            end
        end
    endtask

    task automatic cycle();
        slave_drive();
        #1;
        compare();
        @(posedge clk);
        model_update();
        slave_update();
        #1;
    endtask

    task automatic issue(input logic [31:0] byte_addr);
        int budget = 50;
        req_valid = 1'b1;
        req_addr  = byte_addr[31:1];
        do begin
            cycle();
            budget--;
        end while (!last_req_hs && budget > 0);
        check("issue_timeout", last_req_hs, 1);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        while ((sq.size() > 0 || bq.size() > 0 || m_ar_pend) && budget > 0) begin
            cycle();
            budget--;
        end
        check(name, budget > 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    vec_t vecs[7];

    initial begin
        vecs = '{
            '{32'h0000_101A, 32'h0000_1018},
            '{32'h0000_0000, 32'h0000_0000},
            '{32'h0000_0006, 32'h0000_0000},
            '{32'h0000_001E, 32'h0000_0018},
            '{32'hFFFF_FFFE, 32'hFFFF_FFF8},
            '{32'h1234_5672, 32'h1234_5670},
            '{32'h8000_000C, 32'h8000_0008}
        };
        rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;

        // Reset state.
        repeat (3) cycle();
        check("reset_arvalid", axi_bus.axi_arvalid_f, 0);
        check("reset_araddr", axi_bus.axi_araddr_f, 0);
        check("reset_perr", protocol_err, 0);
        check("reset_rready_empty", axi_bus.axi_rready_f, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;

        // Single refills from the vector table.
        rsp_prob = 100;
        for (int i = 0; i < 7; i++) begin
            dq.delete();
            r_prob = 40 + i * 10;
            issue(vecs[i].byte_addr);
            check("tv_arvalid", axi_bus.axi_arvalid_f, 1);
            check("tv_araddr", axi_bus.axi_araddr_f, vecs[i].exp_araddr);
            drain("tv_drain", 60);
            check("tv_beats", dq.size(), Beats);
            for (int j = 0; j < dq.size(); j++) begin
                check("tv_last", dq[j].last, j == Beats - 1);
                check("tv_order", dq[j].data[31:0] - dq[0].data[31:0], j);
            end
        end

        // Back-to-back: third request blocked until the first burst pops.
        dq.delete(); r_prob = 0; ar_prob = 100;
        issue(32'h100);
        issue(32'h208);
        req_valid = 1'b1;
        req_addr  = 31'h180;
        repeat (4) begin
            cycle();
            check("b2b_full_no_accept", last_req_hs, 0);
        end
        check("b2b_full_ready", req_ready, 0);
        r_prob = 100;
        begin
            int budget = 30;
            do begin cycle(); budget--; end while (!last_req_hs && budget > 0);
            check("b2b_accept_timeout", last_req_hs, 1);
        end
        check("b2b_pop_before_accept", dq.size() >= Beats, 1);
        req_valid = 1'b0;
        drain("b2b_drain", 60);
        check("b2b_beats", dq.size(), 3 * Beats);
        for (int j = 0; j < dq.size(); j++)
            check("b2b_order", dq[j].data[31:0] - dq[0].data[31:0], j);

        // Flush after two ARs are accepted: every beat dropped, then a fresh refill works.
        dq.delete(); r_prob = 0;
        issue(32'h400);
        issue(32'h440);
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        r_prob = 100;
        drain("flush_drain", 60);
        check("flush_dropped", dq.size(), 0);
        issue(32'h480);
        drain("flush_new_drain", 60);
        check("flush_new_beats", dq.size(), Beats);

        // clr while AR is stalled: AR held, beats dropped after acceptance.
        dq.delete(); ar_prob = 0;
        issue(32'h500);
        cycle(); cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle(); cycle();
        check("stall_arvalid", axi_bus.axi_arvalid_f, 1);
        check("stall_araddr", axi_bus.axi_araddr_f, 32'h500);
        ar_prob = 100;
        drain("stall_drain", 60);
        check("stall_dropped", dq.size(), 0);

        // Backpressure and per-beat error.
        dq.delete(); err_beat = 1; rsp_prob = 0;
        issue(32'h600);
        repeat (3) begin
            cycle();
            check("bp_rready", s_rready, 0);
        end
        check("bp_no_loss", bq.size(), Beats);
        rsp_prob = 100;
        drain("bp_drain", 60);
        err_beat = -1;
        check("bp_beats", dq.size(), Beats);
        for (int j = 0; j < dq.size(); j++)
            check("bp_err_flag", dq[j].resp[1], j == 1);

        // Protocol: early rlast, stickiness, beat with empty FIFO, bad rid, beats after reset.
        short_burst = 1;
        issue(32'h700);
        drain("perr_early_drain", 60);
        short_burst = 0;
        check("perr_early_last", protocol_err, 1);
        repeat (3) cycle();
        check("perr_sticky", protocol_err, 1);
        do_reset();
        check("perr_cleared", protocol_err, 0);
        begin
            beat_t b;
            b.data = 64'hDEAD_BEEF_0BAD_F00D; b.resp = 2'b00; b.last = 1'b1; b.id = 4'h0;
            bq.push_back(b);
        end
        drain("perr_empty_drain", 20);
        check("perr_empty_fifo", protocol_err, 1);
        do_reset();
        bad_id = 1;
        issue(32'h740);
        drain("perr_rid_drain", 60);
        bad_id = 0;
        check("perr_rid", protocol_err, 1);
        do_reset();
        issue(32'h800);
        cycle(); cycle();
        do_reset();
        drain("perr_reset_drain", 60);
        check("perr_after_reset", protocol_err, 1);
        do_reset();

        // Randomized traffic against the reference model.
        rand_resp = 1; ar_prob = 60; r_prob = 70; rsp_prob = 70;
        for (int c = 0; c < 1500; c++) begin
            req_valid = 1'($urandom);
            req_addr  = 31'($urandom);
            clr       = ($urandom_range(24) == 0);
            cycle();
        end
        clr = 1'b0; req_valid = 1'b0; rand_resp = 0;
        drain("rand_drain", 400);
        check("rand_perr", protocol_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_axi_ctrl.md
# ifu_fetch_axi_ctrl

Parametrised AXI4 read-side fetch controller for the IFU, replacing the fixed 64-bit single-burst controller. It turns instruction-line refill requests into critical-beat-first WRAP bursts on the fetch AR channel. It tracks up to `NumOut` outstanding bursts, and it discards the R beats of bursts made stale by a pipeline clear. R beats are forwarded to the fetch buffer with per-beat error status. Protocol violations on R are flagged with a sticky error.

## Interface
- `AxiIdW`, default 4: AXI ID width; `axi_arid_f` is always 0.
- `DataW`, default 64: R data width in bits; must be 32, 64 or 128.
- `LineBytes`, default 32: refill line size in bytes; must be a power of two and ≥ DataW/8. Beats per burst: `Beats` = LineBytes/(DataW/8), which must be ≤ 16.
- `NumOut`, default 2: maximum outstanding bursts; must be ≥ 1.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `clr` in 1: flush. Marks every in-flight burst stale.
- `req_valid` in 1, `req_ready` out 1, `req_addr` in [31:1]: refill request (halfword address).
- `rsp_valid` out 1, `rsp_ready` in 1: response beat handshake.
- `rsp_data` out DataW: beat data.
- `rsp_err` out 1: beat has `axi_rresp_f`[1]=1 (SLVERR/DECERR).
- `rsp_last` out 1: last beat of the burst.
- `protocol_err` out 1: sticky protocol-violation flag.
- AR channel, direction out except `axi_arready_f` (in):
  - `axi_arid_f` [AxiIdW-1:0], `axi_araddr_f` [31:0], `axi_arlen_f` [7:0], `axi_arsize_f` [2:0], `axi_arburst_f` [1:0], `axi_arlock_f`, `axi_arcache_f` [3:0], `axi_arprot_f` [2:0], `axi_arvalid_f`, `axi_arqos_f` [3:0], `axi_arregion_f` [3:0].
- R channel, direction in except `axi_rready_f` (out):
  - `axi_rid_f` [AxiIdW-1:0], `axi_rdata_f` [DataW-1:0], `axi_rresp_f` [1:0], `axi_rlast_f`, `axi_rvalid_f`, `axi_rready_f`.

## Operation
- **AR constants:**
  - arburst = WRAP, arlock = 0, arcache = 4'b0011, arprot = 3'b100, arqos = 0, arregion = 0, arid = 0.
  - arsize = log2(DataW/8); arlen = Beats-1.
- **Address:** araddr = {req_addr,1'b0} with the low log2(DataW/8) bits cleared. This gives the critical beat first, and the interconnect wraps the burst at the LineBytes boundary.
- **AR state machine** has two states, AR_IDLE and AR_PEND.
  - `req_ready` = AR_IDLE && count < NumOut && !clr.
  - On a request handshake: register the address, go to AR_PEND, drive arvalid=1, and push an entry {stale=0} into the in-flight FIFO (depth NumOut).
  - In AR_PEND, arvalid and the AR fields are held stable until arready. Then return to AR_IDLE.
  - `clr` never withdraws arvalid.
- **In-flight FIFO:**
  - Holds one stale bit per issued burst, in issue order. Ordering is valid because all bursts share one ID.
  - `clr` sets the stale bit of every occupied entry, including one pushed in the same cycle.
  - The head entry pops on the R handshake with rlast=1.
- **R path** (combinational passthrough, head = FIFO head):
  - `rsp_valid` = rvalid && !empty && !head.stale.
  - `axi_rready_f` = empty || head.stale || rsp_ready.
  - `rsp_data` = rdata; `rsp_err` = rresp[1]; `rsp_last` = rlast.
  - Beats of stale bursts are accepted and dropped.
- **Beat counter:** counts R handshakes in the current burst and clears on the rlast handshake.
- **protocol_err** is set if any of the following occurs, and stays set until reset:
  - an R handshake arrives while the FIFO is empty (the beat is dropped);
  - rlast=1 when the counter ≠ Beats-1;
  - rlast=0 when the counter = Beats-1;
  - rid ≠ 0.
- **count:** FIFO occupancy, width clog2(NumOut+1). A push and a pop in the same cycle leave count unchanged.

## Timing
- Reset values: arvalid=0, araddr=0, req_ready=0 during reset, FIFO empty, counter=0, protocol_err=0, state AR_IDLE.
- rsp_valid/rsp_data follow R combinationally. `axi_rready_f` is 1 while empty.
- Request handshake at cycle N → arvalid=1 from N+1.
- Earliest next request: the cycle after arready, when count < NumOut.
- With arready tied to 1, bursts issue every 2 cycles.
- Full FIFO: req_ready=0 until the rlast pop. A pop and a request in the same cycle are both allowed, because count uses the pre-pop value and the request is refused when count = NumOut.
- `clr` coinciding with a beat of a live burst: that beat is still delivered. Stale takes effect from the next cycle.
- Reset mid-burst: all state is cleared. Beats arriving after reset set protocol_err. The system therefore resets the interconnect together with this block.

## Test plan
- **Single refill** (DataW=64, LineBytes=32): req_addr byte 0x101A → araddr 0x1018, arlen 3, arsize 3, arburst WRAP. Four beats are forwarded, with rsp_last on beat 4 only.
- **Back-to-back** (NumOut=2, arready=1): three requests → the third sees req_ready=0 until the first rlast pop. The beats of the two bursts are delivered in order.
- **Flush:** issue 2 bursts, pulse clr after AR accept → all 8 beats are accepted with rsp_valid=0 throughout. A new request after clr has its 4 beats delivered.
- **clr while arvalid stalled** (arready=0 for 5 cycles): arvalid and araddr are held stable. After acceptance, the burst's beats are dropped.
- **Backpressure and error:** rsp_ready=0 for 3 cycles → axi_rready_f=0 and no beat is lost. rresp=2'b10 on beat 2 → rsp_err=1 on that beat only.
- **Protocol:** rlast on beat 2 of 4 → protocol_err=1 and remains set. A beat with the FIFO empty → protocol_err=1.
